// File: rtl/frame_read_requester_if.sv
// AXI4 read-address and read-data observation signals between the scanout
// read requester (master) and the DDR wrapper / read FIFO side (slave).
interface frame_read_requester_if #(
  parameter int ADDR_W = 27
);
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic              s_axi_rvalid;
  logic              s_axi_rready;
  logic [1:0]        s_axi_rresp;

  modport master (
    output s_axi_arvalid,
    output s_axi_araddr,
    input  s_axi_arready,
    input  s_axi_rvalid,
    input  s_axi_rready,
    input  s_axi_rresp
  );

  modport slave (
    input  s_axi_arvalid,
    input  s_axi_araddr,
    output s_axi_arready,
    output s_axi_rvalid,
    output s_axi_rready,
    output s_axi_rresp
  );
endinterface

// File: rtl/frame_read_requester.sv
// Framebuffer scanout read requester: issues one single-beat AXI read per chunk,
// credit-limits in-flight reads and flags the final returned beat as TLAST.
// Optional READ_ERR_COUNT_EN adds a saturating count of error responses.
//
// state | meaning
// IDLE  | waiting for start_frame_in
// ISSUE | issuing read addresses for the frame, credit permitting
// DRAIN | all addresses sent, waiting for the final beat
module frame_read_requester #(
  parameter int FRAME_CHUNKS    = 7200,
  parameter int MAX_OUTSTANDING = 16,
  parameter int ADDR_W          = 27
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start_frame_in,
  input  logic                   frame_select_in,
  output logic                   frame_out,
  output logic                   busy_out,
  output logic                   frame_done_out,
  output logic                   last_frame_chunk,
`ifdef READ_ERR_COUNT_EN
  output logic [15:0]            err_count_out,
`endif
  frame_read_requester_if.master axi
);

  localparam int IDX_W = (FRAME_CHUNKS > 1) ? $clog2(FRAME_CHUNKS) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_CHUNKS - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t           state;
  logic [IDX_W-1:0] ar_idx;
  logic [IDX_W-1:0] beat_idx;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_nxt;
  logic             arvalid_q;
  logic             ar_hs;
  logic             r_beat;
  logic             beat_ok;
  logic             final_beat;

  assign ar_hs      = arvalid_q && axi.s_axi_arready;
  assign r_beat     = axi.s_axi_rvalid && axi.s_axi_rready;
  // A beat with no read in flight is a protocol error and is not counted.
  assign beat_ok    = r_beat && (outstanding != '0);
  assign final_beat = beat_ok && (beat_idx == LAST_IDX);

  assign axi.s_axi_arvalid = arvalid_q;
  assign axi.s_axi_araddr  = ADDR_W'(ar_idx);
  assign last_frame_chunk  = axi.s_axi_rvalid && (beat_idx == LAST_IDX);

  always_comb begin
    outstanding_nxt = outstanding;
    if (ar_hs && !beat_ok)
      outstanding_nxt = outstanding + CNT_W'(1);
    else if (!ar_hs && beat_ok)
      outstanding_nxt = outstanding - CNT_W'(1);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= IDLE;
      ar_idx         <= '0;
      beat_idx       <= '0;
      outstanding    <= '0;
      arvalid_q      <= 1'b0;
      frame_out      <= 1'b0;
      busy_out       <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      outstanding    <= outstanding_nxt;
      frame_done_out <= 1'b0;
      if (beat_ok)
        beat_idx <= beat_idx + 1'b1;

      case (state)
        IDLE: begin
          if (start_frame_in) begin
            state     <= ISSUE;
            frame_out <= frame_select_in;
            busy_out  <= 1'b1;
            ar_idx    <= '0;
            beat_idx  <= '0;
            arvalid_q <= (outstanding_nxt < MAX_CNT);
          end
        end
        ISSUE: begin
          if (ar_hs) begin
            if (ar_idx == LAST_IDX) begin
              state     <= DRAIN;
              arvalid_q <= 1'b0;
            end else begin
              ar_idx    <= ar_idx + 1'b1;
              arvalid_q <= (outstanding_nxt < MAX_CNT);
            end
          end else if (!arvalid_q) begin
            // A raised request is held until accepted; only raise on credit.
            arvalid_q <= (outstanding_nxt < MAX_CNT);
          end
        end
        DRAIN: begin
          arvalid_q <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          arvalid_q <= 1'b0;
        end
      endcase

      if (final_beat) begin
        state          <= IDLE;
        busy_out       <= 1'b0;
        frame_done_out <= 1'b1;
        arvalid_q      <= 1'b0;
        beat_idx       <= '0;
      end
    end
  end

`ifdef READ_ERR_COUNT_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      err_count_out <= '0;
    else if (beat_ok && (axi.s_axi_rresp != 2'b00) && (err_count_out != 16'hFFFF))
      err_count_out <= err_count_out + 16'd1;
  end
`else
  logic unused_rresp;
  assign unused_rresp = ^axi.s_axi_rresp;
`endif

  a_r_underflow: assert property (@(posedge clk_in) disable iff (rst_in)
    !(r_beat && (outstanding == '0)));

endmodule

// File: tb/tb_frame_read_requester.sv
// Directed bench for frame_read_requester: 8-chunk frame, 4 credits, memory
// model with 2-cycle read latency; covers credits, AR stalls, ignored starts, reset abort.
module tb_frame_read_requester;
  localparam int FC = 8;
  localparam int MO = 4;
  localparam int AW = 27;

  logic clk = 1'b0;
  logic rst;
  logic start_frame;
  logic frame_select;
  logic frame_out;
  logic busy;
  logic frame_done;
  logic last_chunk;
  logic err_frame;
`ifdef READ_ERR_COUNT_EN
  logic [15:0] err_count;
`endif

  frame_read_requester_if #(.ADDR_W(AW)) bus ();

  frame_read_requester #(
    .FRAME_CHUNKS(FC),
    .MAX_OUTSTANDING(MO),
    .ADDR_W(AW)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .start_frame_in(start_frame),
    .frame_select_in(frame_select),
    .frame_out(frame_out),
    .busy_out(busy),
    .frame_done_out(frame_done),
    .last_frame_chunk(last_chunk),
`ifdef READ_ERR_COUNT_EN
    .err_count_out(err_count),
`endif
    .axi(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Memory model / monitor state, written only by the memory process.
  int cyc = 0;
  int ar_count = 0;
  int beat_count = 0;
  int last_hits = 0;
  int last_final = 0;
  int done_count = 0;
  int outstanding = 0;
  int max_out = 0;
  int addr_err = 0;
  int first_ar_cyc = 0;
  int last_ar_cyc = 0;
  int due_q[$];
  bit ar_hs;
  bit r_hs;

  initial begin
    bus.s_axi_rvalid = 1'b0;
    bus.s_axi_rresp  = 2'b00;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        due_q.delete();
        outstanding      = 0;
        bus.s_axi_rvalid = 1'b0;
        bus.s_axi_rresp  = 2'b00;
      end else begin
        if (start_frame && !busy) begin
          ar_count = 0; beat_count = 0; last_hits = 0; last_final = 0;
          max_out = 0; addr_err = 0;
        end
        if (frame_done) done_count++;
        ar_hs = bus.s_axi_arvalid && bus.s_axi_arready;
        r_hs  = bus.s_axi_rvalid && bus.s_axi_rready;
        if (r_hs) begin
          if (last_chunk) begin
            last_hits++;
            if (beat_count == FC - 1) last_final = 1;
          end
          beat_count++;
          void'(due_q.pop_front());
          outstanding--;
        end
        if (ar_hs) begin
          if (bus.s_axi_araddr != AW'(ar_count)) addr_err++;
          if (ar_count == 0) first_ar_cyc = cyc;
          last_ar_cyc = cyc;
          ar_count++;
          due_q.push_back(cyc + 2);
          outstanding++;
        end
        if (outstanding > max_out) max_out = outstanding;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!rst) begin
        bus.s_axi_rvalid = (due_q.size() > 0) && (due_q[0] <= cyc);
        bus.s_axi_rresp  = (err_frame && beat_count < 3 && bus.s_axi_rvalid) ? 2'b10 : 2'b00;
      end
    end
  end

  task automatic start_pulse(input logic sel);
    @(negedge clk);
    start_frame  = 1'b1;
    frame_select = sel;
    @(negedge clk);
    start_frame  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      #4;
      n++;
    end
    check({tag, "_timeout"}, busy, 0);
  endtask

  initial begin
    int n;
    int d0;
    logic ok;
    rst = 1'b1; start_frame = 1'b0; frame_select = 1'b0; err_frame = 1'b0;
    bus.s_axi_arready = 1'b0; bus.s_axi_rready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_frame_out", frame_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_arvalid", bus.s_axi_arvalid, 0);
    check("rst_araddr", bus.s_axi_araddr, 0);
    check("rst_last", last_chunk, 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic frame, free-flowing handshakes
    @(negedge clk);
    bus.s_axi_arready = 1'b1; bus.s_axi_rready = 1'b1;
    d0 = done_count;
    start_pulse(1'b1);
    #1;
    check("t1_busy", busy, 1);
    check("t1_frame_out", frame_out, 1);
    check("t1_arvalid", bus.s_axi_arvalid, 1);
    check("t1_araddr0", bus.s_axi_araddr, 0);
    wait_idle("t1");
    repeat (3) @(negedge clk);
    #4;
    check("t1_ar_count", ar_count, 8);
    check("t1_addr_err", addr_err, 0);
    check("t1_ar_span", last_ar_cyc - first_ar_cyc, 7);
    check("t1_beats", beat_count, 8);
    check("t1_last_hits", last_hits, 1);
    check("t1_last_final", last_final, 1);
    check("t1_done_once", done_count - d0, 1);
    check("t1_frame_hold", frame_out, 1);

    // Credit limit with rready held low
    @(negedge clk);
    bus.s_axi_rready = 1'b0;
    d0 = done_count;
    start_pulse(1'b0);
    repeat (12) @(negedge clk);
    #4;
    check("t2_ar_capped", ar_count, 4);
    check("t2_arvalid_low", bus.s_axi_arvalid, 0);
    check("t2_max_out", max_out, 4);
    check("t2_frame_out", frame_out, 0);
    check("t2_last_low", last_chunk, 0);
    @(negedge clk);
    bus.s_axi_rready = 1'b1;
    wait_idle("t2");
    check("t2_ar_count", ar_count, 8);
    check("t2_beats", beat_count, 8);
    check("t2_max_out_end", max_out, 4);
    check("t2_addr_err", addr_err, 0);
    check("t2_last_final", last_final, 1);
    check("t2_done_once", done_count - d0, 1);

    // AR stall at address 3
    d0 = done_count;
    start_pulse(1'b1);
    n = 0;
    while (!(bus.s_axi_arvalid && bus.s_axi_araddr == 3) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t3_reach_addr3", (n < 50) ? 1 : 0, 1);
    bus.s_axi_arready = 1'b0;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (!(bus.s_axi_arvalid && bus.s_axi_araddr == 3)) ok = 1'b0;
    end
    check("t3_stall_hold", ok, 1);
    check("t3_ar_count_stall", ar_count, 3);
    @(negedge clk);
    bus.s_axi_arready = 1'b1;
    #4;
    check("t3_release_count", ar_count, 4);
    check("t3_release_addr", addr_err, 0);
    wait_idle("t3");
    check("t3_beats", beat_count, 8);
    check("t3_done_once", done_count - d0, 1);

    // Start while busy is ignored
    d0 = done_count;
    start_pulse(1'b1);
    repeat (3) @(negedge clk);
    start_frame = 1'b1; frame_select = 1'b0;
    @(negedge clk);
    start_frame = 1'b0;
    #4;
    check("t4_frame_out", frame_out, 1);
    check("t4_busy", busy, 1);
    wait_idle("t4");
    check("t4_ar_count", ar_count, 8);
    check("t4_beats", beat_count, 8);
    check("t4_done_once", done_count - d0, 1);
    check("t4_frame_end", frame_out, 1);

    // Reset mid-frame
    start_pulse(1'b0);
    n = 0;
    while (ar_count < 5 && n < 50) begin
      @(negedge clk);
      #4;
      n++;
    end
    check("t5_reach_5", (n < 50) ? 1 : 0, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_rst_arvalid", bus.s_axi_arvalid, 0);
    check("t5_rst_araddr", bus.s_axi_araddr, 0);
    check("t5_rst_busy", busy, 0);
    d0 = done_count;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #4;
    check("t5_no_done", done_count - d0, 0);
    start_pulse(1'b1);
    #1;
    check("t5_restart_arvalid", bus.s_axi_arvalid, 1);
    check("t5_restart_addr", bus.s_axi_araddr, 0);
    wait_idle("t5");
    check("t5_addr_err", addr_err, 0);
    check("t5_ar_count", ar_count, 8);
    check("t5_beats", beat_count, 8);
    check("t5_done_once", done_count - d0, 1);

`ifdef READ_ERR_COUNT_EN
    check("t6_err_initial", err_count, 0);
    @(negedge clk);
    err_frame = 1'b1;
    start_pulse(1'b0);
    wait_idle("t6a");
    check("t6_err_three", err_count, 3);
    @(negedge clk);
    err_frame = 1'b0;
    start_pulse(1'b1);
    wait_idle("t6b");
    check("t6_err_persist", err_count, 3);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
